// File: rtl/ysyx_22050518_addsub_pipe.sv
// ysyx_22050518_addsub_pipe: segmented add/subtract pipeline, SEG bits per stage, valid/ready handshake.
// Define YSYX_22050518_ADD_WORD_EN to add a 'word' input for 32-bit sign-extended results.
module ysyx_22050518_addsub_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             c_in,
`ifdef YSYX_22050518_ADD_WORD_EN
    input  logic             word,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / SEG;
    if (WIDTH % SEG != 0) begin : g_seg_chk
        $error("WIDTH must be a multiple of SEG");
    end
`ifdef YSYX_22050518_ADD_WORD_EN
    if (WIDTH != 64 || 32 % SEG != 0) begin : g_word_chk
        $error("word mode needs WIDTH=64 and SEG dividing 32");
    end
    logic [N-1:0] w_q, w_d, sw;
`endif
    logic adv, an, bn, rn, cy;
    logic [SEG:0] t;
    logic [N-1:0] v_q, v_d, c_q, c_d, sv, sc;
    logic [N-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sa, sb, sr;
    // b travels pre-inverted for subtract so every stage is a plain add
    always_comb begin
        adv = !v_q[N-1] || out_ready;
        sv[0] = in_valid;
        sa[0] = in1;
        sb[0] = sub ? ~in2 : in2;
        sc[0] = sub | c_in;
        sr[0] = '0;
`ifdef YSYX_22050518_ADD_WORD_EN
        sw[0] = word;
        w_d = w_q;
`endif
        for (int k = 1; k < N; k++) begin
            sv[k] = v_q[k-1];
            sa[k] = a_q[k-1];
            sb[k] = b_q[k-1];
            sc[k] = c_q[k-1];
            sr[k] = r_q[k-1];
`ifdef YSYX_22050518_ADD_WORD_EN
            sw[k] = w_q[k-1];
`endif
        end
        t = '0;
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        if (adv) begin
            for (int k = 0; k < N; k++) begin
                t = {1'b0, sa[k][k*SEG +: SEG]} + {1'b0, sb[k][k*SEG +: SEG]} + {{SEG{1'b0}}, sc[k]};
                r_d[k] = sr[k];
                r_d[k][k*SEG +: SEG] = t[SEG-1:0];
                c_d[k] = t[SEG];
                a_d[k] = sa[k];
                b_d[k] = sb[k];
                v_d[k] = sv[k];
`ifdef YSYX_22050518_ADD_WORD_EN
                w_d[k] = sw[k];
`endif
            end
        end
        if (flush) v_d = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
`ifdef YSYX_22050518_ADD_WORD_EN
            w_q <= '0;
`endif
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
`ifdef YSYX_22050518_ADD_WORD_EN
            w_q <= w_d;
`endif
        end
    end
    // carry out of any bit follows from its operand and result bits: a&b | (a^b)&~r
    always_comb begin
        out = r_q[N-1];
        an  = a_q[N-1][WIDTH-1];
        bn  = b_q[N-1][WIDTH-1];
        rn  = r_q[N-1][WIDTH-1];
        cy  = c_q[N-1];
`ifdef YSYX_22050518_ADD_WORD_EN
        if (w_q[N-1]) begin
            out = {{32{r_q[N-1][31]}}, r_q[N-1][31:0]};
            an  = a_q[N-1][31];
            bn  = b_q[N-1][31];
            rn  = r_q[N-1][31];
            cy  = (an & bn) | ((an ^ bn) & ~rn);
        end
`endif
        c_out = cy;
        ovf   = (an == bn) && (rn != an);
        zero  = v_q[N-1] && (out == '0);
    end
    assign in_ready  = adv;
    assign out_valid = v_q[N-1];
endmodule

// File: tb/tb_ysyx_22050518_addsub_pipe.sv
// tb_ysyx_22050518_addsub_pipe: random and directed checks of the add/sub pipeline against a plain-arithmetic model.
module tb_ysyx_22050518_addsub_pipe;
    localparam int W = 64, S = 16, N = W / S;
`ifdef YSYX_22050518_ADD_WORD_EN
    localparam bit WEN = 1;
`else
    localparam bit WEN = 0;
`endif
    logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, sub = 0, c_in = 0, word = 0;
    logic out_valid, out_ready = 1, c_out, ovf, zero;
    logic [W-1:0] in1 = '0, in2 = '0, out;
    int checks = 0, errors = 0, cyc_n = 0, nfire = 0, first_f = -1, last_f = -1;
    logic [W+2:0] expq[$];
    logic [W+2:0] o_s, snap, e;
    logic ov_s, ir_s;

    ysyx_22050518_addsub_pipe #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .sub(sub), .c_in(c_in),
`ifdef YSYX_22050518_ADD_WORD_EN
        .word(word),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W+2:0] got, input logic [W+2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci, input logic w);
        logic [W-1:0] bb = s ? ~b : b;
        logic cc = s ? 1'b1 : ci;
        logic [W:0] f = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        logic [32:0] h = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + {32'd0, cc};
        logic [W-1:0] o;
        logic c, v;
        if (w) begin
            o = {{32{h[31]}}, h[31:0]};
            c = h[32];
            v = (a[31] == bb[31]) && (h[31] != a[31]);
        end else begin
            o = f[W-1:0];
            c = f[W];
            v = (a[W-1] == bb[W-1]) && (f[W-1] != a[W-1]);
        end
        return {o, c, v, o == '0};
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0: return '1;
            1: return {1'b0, {(W-1){1'b1}}};
            2: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci,
                       input logic w, input logic ordy, input logic fl, input logic r);
        @(negedge clk);
        in_valid = iv; in1 = a; in2 = b; sub = s; c_in = ci; word = w & WEN;
        out_ready = ordy; flush = fl; rst = r;
        #1;
        ov_s = out_valid;
        ir_s = in_ready;
        o_s = {out, c_out, ovf, zero};
        if (r || fl) expq.delete();
        else begin
            if (out_valid && out_ready) begin
                nfire++;
                if (first_f < 0) first_f = cyc_n;
                last_f = cyc_n;
                if (expq.size() == 0) chk("spurious", {{(W+2){1'b0}}, out_valid}, '0);
                else begin
                    e = expq.pop_front();
                    chk("out", {3'b0, out}, {3'b0, e[W+2:3]});
                    chk("c_out", {{(W+2){1'b0}}, c_out}, {{(W+2){1'b0}}, e[2]});
                    chk("ovf", {{(W+2){1'b0}}, ovf}, {{(W+2){1'b0}}, e[1]});
                    chk("zero", {{(W+2){1'b0}}, zero}, {{(W+2){1'b0}}, e[0]});
                end
            end
            if (in_valid && in_ready) expq.push_back(ref_op(a, b, s, ci, w & WEN));
        end
        @(posedge clk);
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci, input logic w);
        cyc(1, a, b, s, ci, w, 1, 0, 0);
    endtask

    task automatic lat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci);
        op(a, b, s, ci, 0);
        for (int i = 1; i <= N; i++) begin
            cyc(0, '0, '0, 0, 0, 0, 1, 0, 0);
            chk(tag, {{(W+2){1'b0}}, ov_s}, {{(W+2){1'b0}}, i == N});
        end
    endtask

    task automatic drop(input logic ur);
        for (int i = 0; i < 3; i++) op(rnd(), rnd(), $urandom_range(0, 1), $urandom_range(0, 1), 0);
        cyc(1, rnd(), rnd(), 0, 0, 0, 1, !ur, ur);
        cyc(0, '0, '0, 0, 0, 0, 1, 0, 0);
        chk(ur ? "rst_ov" : "flush_ov", {{(W+2){1'b0}}, ov_s}, '0);
        chk(ur ? "rst_ir" : "flush_ir", {{(W+2){1'b0}}, ir_s}, {{(W+2){1'b0}}, 1'b1});
        idle(N + 2);
        lat(ur ? "rst_lat" : "flush_lat", rnd(), rnd(), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    initial begin
        cyc(0, '0, '0, 0, 0, 0, 1, 0, 1);
        cyc(0, '0, '0, 0, 0, 0, 1, 0, 1);
        cyc(0, '0, '0, 0, 0, 0, 1, 0, 0);
        chk("rst_ov", {{(W+2){1'b0}}, ov_s}, '0);
        chk("rst_ir", {{(W+2){1'b0}}, ir_s}, {{(W+2){1'b0}}, 1'b1});
        chk("rst_outs", o_s, '0);
        lat("lat", '1, 64'd1, 0, 0);
        op({1'b0, {(W-1){1'b1}}}, 64'd1, 0, 0, 0);
        op(64'd5, 64'd7, 1, 1, 0);
        idle(N + 1);
        first_f = -1;
        nfire = 0;
        for (int i = 0; i < 8; i++) op(rnd(), rnd(), $urandom_range(0, 1), $urandom_range(0, 1), 0);
        idle(N + 2);
        chk("stream_n", nfire, 8);
        chk("stream_gap", last_f - first_f, 7);
        for (int i = 0; i < 6; i++) cyc(1, rnd(), rnd(), $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0);
        snap = o_s;
        for (int i = 0; i < 3; i++) begin
            cyc(1, rnd(), rnd(), 0, 0, 0, 0, 0, 0);
            chk("stall_ir", {{(W+2){1'b0}}, ir_s}, '0);
            chk("stall_out", o_s, snap);
        end
        idle(N + 2);
        chk("stall_drain", expq.size(), 0);
        drop(0);
        drop(1);
        if (WEN) begin
            op(64'h7FFFFFFF, 64'd1, 0, 0, 1);
            idle(N + 1);
        end
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, rnd(), rnd(), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, 0);
        idle(N + 2);
        chk("final_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22050518_addsub_pipe.md
YSYX_22050518_ADDSUB_PIPE -- requirements
Module: ysyx_22050518_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the operand and result width in bits.
REQ-002 Parameter SEG, default 16, SHALL set the bits added per pipeline stage; WIDTH SHALL be a multiple of SEG, and N = WIDTH/SEG SHALL be the stage count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 flush  input  1  SHALL be a synchronous drop of all in-flight operations.
REQ-006 in_valid / in_ready  input / output  1 / 1  SHALL be the operand handshake.
REQ-007 in1, in2  input  WIDTH  SHALL be the operands.
REQ-008 sub  input  1  SHALL select subtract (1) or add (0).
REQ-009 c_in  input  1  SHALL be the carry-in, used only when sub=0.
REQ-010 out_valid / out_ready  output / input  1 / 1  SHALL be the result handshake.
REQ-011 out  output  WIDTH  SHALL be the sum or difference.
REQ-012 c_out, ovf, zero  output  1 each  SHALL be the unsigned carry-out, the signed overflow flag and the (out==0) flag.

Function
REQ-013 Add SHALL compute in1 + in2 + c_in; subtract SHALL compute in1 + ~in2 + 1, with c_in ignored.
REQ-014 Stage k (0..N-1) SHALL add bits [k*SEG +: SEG] using the registered carry from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-015 Operand slices not yet added and result slices already produced SHALL travel with each stage's valid bit.
REQ-016 All stages SHALL advance together when adv = !out_valid || out_ready; otherwise every stage SHALL hold.
REQ-017 in_ready SHALL equal adv, combinationally.
REQ-018 A transaction is accepted on a rising edge where in_valid && in_ready.
REQ-019 An operation accepted at edge t SHALL present out_valid=1 after edge t+N-1 if no stall occurs (latency N cycles; N=1 when SEG=WIDTH).
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1; ordering SHALL be preserved.
REQ-021 out, c_out, ovf and zero SHALL remain stable while out_valid=1 && out_ready=0.
REQ-022 ovf SHALL be 1 when the operand sign bits (in2 inverted for subtract) are equal and the result sign differs.
REQ-023 c_out SHALL be the carry out of bit WIDTH-1; for subtract, c_out=1 means no borrow.
REQ-024 flush=1 SHALL clear every stage valid bit and out_valid at the next edge; flush SHALL override a simultaneous acceptance; in_ready SHALL stay defined as adv during flush.
REQ-025 When out_valid=1, out_ready=1 and in_valid=1 occur in the same cycle, output and input transfers SHALL both complete.

Reset
REQ-026 rst=1 at an edge SHALL clear all valid bits, so out_valid=0 and in_ready=1 in the following cycle.
REQ-027 rst=1 SHALL set out=0, c_out=0, ovf=0 and zero=0.
REQ-028 Reset asserted while operations are in flight SHALL discard them, and no result SHALL appear after reset release.
REQ-029 rst SHALL take priority over flush and over acceptance.

Configuration
REQ-030 Macro YSYX_22050518_ADD_WORD_EN defined: an input port word (1 bit, travelling with the operation) SHALL exist; the block SHALL require WIDTH=64 with SEG dividing 32.
REQ-031 With word=1: out SHALL be the sign-extension of result[31:0]; c_out and ovf SHALL be taken at bit 31; zero SHALL reflect the extended out.
REQ-032 Macro undefined: the word port SHALL be absent, and the behaviour SHALL be identical to word=0.

Verification (WIDTH=64, SEG=16, N=4)
REQ-033 Apply in1=0xFFFFFFFFFFFFFFFF, in2=1, sub=0, c_in=0 with out_ready=1 -> 4 cycles later: out=0, c_out=1, zero=1, ovf=0.
REQ-034 Apply in1=0x7FFFFFFFFFFFFFFF, in2=1, sub=0 -> out=0x8000000000000000, ovf=1, c_out=0; then in1=5, in2=7, sub=1 -> out=0xFFFFFFFFFFFFFFFE, c_out=0.
REQ-035 Stream 8 back-to-back random operations with out_ready=1 -> 8 consecutive out_valid cycles, results in order, matching the reference model.
REQ-036 Hold out_ready=0 for 3 cycles with the pipe full -> in_ready=0, outputs stable; release -> no loss, no duplication.
REQ-037 Apply flush (then, separately, rst) with 3 operations in flight -> out_valid=0 the next cycle, no stale result later, and a new operation completes in 4 cycles.
REQ-038 With YSYX_22050518_ADD_WORD_EN: word=1, in1=0x7FFFFFFF, in2=1 -> out=0xFFFFFFFF80000000, ovf=1.
